// File: rtl/bsg_global_buffer_row_dma_if.sv
// Command, write-stream, read-return and buffer-row RO/WO signals of one row DMA.
// Signal suffixes are from the DMA's point of view; the DMA uses the master modport.
interface bsg_global_buffer_row_dma_if #(
  parameter int data_width_p = 32,
  parameter int addr_width_p = 16,
  parameter int len_width_p  = 16
);
  logic                    cmd_op_i;
  logic [addr_width_p-1:0] cmd_base_i;
  logic [addr_width_p-1:0] cmd_stride_i;
  logic [len_width_p-1:0]  cmd_len_i;
  logic                    cmd_v_i;
  logic                    cmd_ready_o;
  logic [data_width_p-1:0] wr_data_i;
  logic                    wr_v_i;
  logic                    wr_yumi_o;
  logic [data_width_p-1:0] rd_data_o;
  logic                    rd_v_o;
  logic                    rd_yumi_i;
  logic                    done_o;
  logic                    error_o;
  logic [addr_width_p-1:0] ro_addr_o;
  logic                    ro_v_o;
  logic [data_width_p-1:0] ro_data_i;
  logic                    ro_v_i;
  logic [addr_width_p-1:0] wo_addr_o;
  logic [data_width_p-1:0] wo_data_o;
  logic                    wo_v_o;
  logic                    wo_ready_i;

  modport master (
    input  cmd_op_i, cmd_base_i, cmd_stride_i, cmd_len_i, cmd_v_i,
    input  wr_data_i, wr_v_i, rd_yumi_i, ro_data_i, ro_v_i, wo_ready_i,
    output cmd_ready_o, wr_yumi_o, rd_data_o, rd_v_o, done_o, error_o,
    output ro_addr_o, ro_v_o, wo_addr_o, wo_data_o, wo_v_o
  );

  modport slave (
    output cmd_op_i, cmd_base_i, cmd_stride_i, cmd_len_i, cmd_v_i,
    output wr_data_i, wr_v_i, rd_yumi_i, ro_data_i, ro_v_i, wo_ready_i,
    input  cmd_ready_o, wr_yumi_o, rd_data_o, rd_v_o, done_o, error_o,
    input  ro_addr_o, ro_v_o, wo_addr_o, wo_data_o, wo_v_o
  );
endinterface

// File: rtl/bsg_global_buffer_row_dma.sv
// Per-row strided burst engine: issues len RO reads or WO writes at base+i*stride.
// Read returns land in a credit-managed FIFO because the RO path cannot be stalled.
module bsg_global_buffer_row_dma #(
  parameter int data_width_p  = 32,
  parameter int addr_width_p  = 16,
  parameter int len_width_p   = 16,
  parameter int rd_fifo_els_p = 4
) (
  input logic                         clk_i,
  input logic                         reset_n_i,
  bsg_global_buffer_row_dma_if.master bus
);
  localparam int ptr_w_lp = $clog2(rd_fifo_els_p);
  localparam int cnt_w_lp = $clog2(rd_fifo_els_p + 1);
  localparam logic [cnt_w_lp-1:0] els_lp      = cnt_w_lp'(rd_fifo_els_p);
  localparam logic [ptr_w_lp-1:0] last_ptr_lp = ptr_w_lp'(rd_fifo_els_p - 1);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_e;

  state_e                  state_q, state_d;
  logic [addr_width_p-1:0] addr_q, addr_d, stride_q, stride_d;
  logic [len_width_p-1:0]  len_q, len_d, issued_q, issued_d;
  logic [cnt_w_lp-1:0]     credits_q, credits_d, outst_q, outst_d, count_q, count_d;
  logic [ptr_w_lp-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                    error_q, error_d;
  logic [data_width_p-1:0] fifo_mem_q [rd_fifo_els_p];

  logic wo_hs, rd_issue, push, pop;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d  = state_q;
    addr_d   = addr_q;
    stride_d = stride_q;
    len_d    = len_q;
    issued_d = issued_q;

    wo_hs    = (state_q == WRITE) && bus.wr_v_i && bus.wo_ready_i;
    rd_issue = (state_q == READ) && (issued_q < len_q) && (credits_q != '0);
    pop      = bus.rd_yumi_i && (count_q != '0);
    // A return is only accepted if a read is outstanding and a slot exists this cycle.
    push     = bus.ro_v_i && (outst_q != '0) && ((count_q != els_lp) || pop);

    error_d   = error_q | (bus.ro_v_i & ~push);
    outst_d   = outst_q + cnt_w_lp'(rd_issue) - cnt_w_lp'(push);
    credits_d = credits_q - cnt_w_lp'(rd_issue) + cnt_w_lp'(pop);
    count_d   = count_q + cnt_w_lp'(push) - cnt_w_lp'(pop);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (push) wr_ptr_d = (wr_ptr_q == last_ptr_lp) ? '0 : wr_ptr_q + ptr_w_lp'(1);
    if (pop)  rd_ptr_d = (rd_ptr_q == last_ptr_lp) ? '0 : rd_ptr_q + ptr_w_lp'(1);

    unique case (state_q)
      IDLE: begin
        if (bus.cmd_v_i) begin
          addr_d   = bus.cmd_base_i;
          stride_d = bus.cmd_stride_i;
          len_d    = bus.cmd_len_i;
          issued_d = '0;
          if (bus.cmd_len_i == '0) state_d = DONE;
          else                     state_d = bus.cmd_op_i ? WRITE : READ;
        end
      end
      WRITE: begin
        if (wo_hs) begin
          addr_d   = addr_q + stride_q;
          issued_d = issued_q + len_width_p'(1);
          if (issued_q + len_width_p'(1) == len_q) state_d = DONE;
        end
      end
      READ: begin
        if (rd_issue) begin
          addr_d   = addr_q + stride_q;
          issued_d = issued_q + len_width_p'(1);
        end
        // Completion only waits for returns, not for the consumer to drain the FIFO.
        if ((issued_q == len_q) && (outst_d == '0)) state_d = DONE;
      end
      DONE: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (!reset_n_i) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      stride_q  <= '0;
      len_q     <= '0;
      issued_q  <= '0;
      credits_q <= els_lp;
      outst_q   <= '0;
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      stride_q  <= stride_d;
      len_q     <= len_d;
      issued_q  <= issued_d;
      credits_q <= credits_d;
      outst_q   <= outst_d;
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      error_q   <= error_d;
    end
  end

  // NOTE: the FIFO storage has no reset; count_q alone defines which entries are valid.
  always_ff @(posedge clk_i) begin
    if (push) fifo_mem_q[wr_ptr_q] <= bus.ro_data_i;
  end

  assign bus.cmd_ready_o = (state_q == IDLE);
  assign bus.done_o      = (state_q == DONE);
  assign bus.error_o     = error_q;
  assign bus.wr_yumi_o   = wo_hs;
  assign bus.wo_v_o      = (state_q == WRITE) && bus.wr_v_i;
  assign bus.wo_addr_o   = addr_q;
  assign bus.wo_data_o   = (state_q == WRITE) ? bus.wr_data_i : '0;
  assign bus.ro_v_o      = rd_issue;
  assign bus.ro_addr_o   = addr_q;
  assign bus.rd_v_o      = (count_q != '0);
  assign bus.rd_data_o   = (count_q != '0) ? fifo_mem_q[rd_ptr_q] : '0;
endmodule

// File: tb/tb_bsg_global_buffer_row_dma.sv
// Directed bench for the row DMA: bursts, backpressure, read credits, wrap, len 0,
// stray returns and reset mid-burst, against a 3-cycle-latency RO buffer model.
module tb_bsg_global_buffer_row_dma;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  bsg_global_buffer_row_dma_if bus ();
  bsg_global_buffer_row_dma dut (.clk_i(clk), .reset_n_i(rst_n), .bus(bus));

  // RO buffer model: a read issued at edge k returns {DA7A, addr} for edge k+3.
  bit          model_en = 1'b1;
  logic        stray_v  = 1'b0;
  logic [31:0] stray_d  = '0;
  logic        pv [3];
  logic [15:0] pa [3];

  always @(negedge clk) begin
    if (!model_en || !rst_n) begin
      for (int i = 0; i < 3; i++) begin pv[i] = 1'b0; pa[i] = '0; end
      bus.ro_v_i    = model_en ? 1'b0 : stray_v;
      bus.ro_data_i = model_en ? 32'h0 : stray_d;
    end else begin
      bus.ro_v_i    = pv[2];
      bus.ro_data_i = pv[2] ? {16'hDA7A, pa[2]} : 32'h0;
      pv[2] = pv[1]; pa[2] = pa[1];
      pv[1] = pv[0]; pa[1] = pa[0];
      pv[0] = bus.ro_v_o; pa[0] = bus.ro_addr_o;
    end
  end

  logic [15:0] rd_base, rd_stride, rd_len;
  int rd_iss, rd_ret, rd_n, rd_done;

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send_cmd(input bit op, input logic [15:0] base, input logic [15:0] stride,
                          input logic [15:0] len);
    checks++;
    if (bus.cmd_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL cmd_ready before accept: got %b want 1", bus.cmd_ready_o);
    end
    bus.cmd_op_i = op; bus.cmd_base_i = base; bus.cmd_stride_i = stride;
    bus.cmd_len_i = len; bus.cmd_v_i = 1'b1;
    step();
    bus.cmd_v_i = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({bus.cmd_ready_o, bus.wr_yumi_o, bus.rd_v_o, bus.done_o, bus.error_o,
         bus.ro_v_o, bus.wo_v_o} !== 7'b1000000) begin
      errors++;
      $display("FAIL reset flags: got %b want 1000000", {bus.cmd_ready_o, bus.wr_yumi_o,
               bus.rd_v_o, bus.done_o, bus.error_o, bus.ro_v_o, bus.wo_v_o});
    end
    checks++;
    if ({bus.rd_data_o, bus.wo_data_o, bus.ro_addr_o, bus.wo_addr_o} !== 96'h0) begin
      errors++;
      $display("FAIL reset buses: rd_data %h wo_data %h ro_addr %h wo_addr %h want 0",
               bus.rd_data_o, bus.wo_data_o, bus.ro_addr_o, bus.wo_addr_o);
    end
  endtask

  task automatic run_write(input logic [15:0] base, input logic [15:0] stride,
                           input logic [15:0] len, input bit bp);
    int idx;
    int cyc;
    logic [15:0] ea;
    logic [31:0] ed;
    bus.wr_v_i = 1'b1; bus.wr_data_i = 32'hA5A5_0000; bus.wo_ready_i = !bp;
    send_cmd(1'b1, base, stride, len);
    idx = 0; cyc = 1;
    while (idx < int'(len) && cyc < 40) begin
      if (bp) bus.wo_ready_i = (cyc % 2 == 0);
      ea = base + 16'(idx) * stride;
      ed = 32'hA5A5_0000 + 32'(idx);
      bus.wr_data_i = ed;
      #1;
      checks++;
      if (bus.wo_v_o !== 1'b1 || bus.wo_addr_o !== ea || bus.wo_data_o !== ed) begin
        errors++;
        $display("FAIL write elem %0d: v %b addr %h data %h want v 1 addr %h data %h",
                 idx, bus.wo_v_o, bus.wo_addr_o, bus.wo_data_o, ea, ed);
      end
      checks++;
      if (bus.wr_yumi_o !== bus.wo_ready_i || bus.ro_v_o !== 1'b0 || bus.done_o !== 1'b0) begin
        errors++;
        $display("FAIL write ctl cyc %0d: yumi %b ro_v %b done %b want yumi %b ro_v 0 done 0",
                 cyc, bus.wr_yumi_o, bus.ro_v_o, bus.done_o, bus.wo_ready_i);
      end
      if (bus.wo_ready_i) idx++;
      step();
      cyc++;
    end
    checks++;
    if (idx != int'(len)) begin
      errors++;
      $display("FAIL write timeout: %0d elements written want %0d", idx, len);
    end
    checks++;
    if (bus.done_o !== 1'b1 || bus.wo_v_o !== 1'b0 || bus.wr_yumi_o !== 1'b0) begin
      errors++;
      $display("FAIL write done: done %b wo_v %b yumi %b want 1 0 0",
               bus.done_o, bus.wo_v_o, bus.wr_yumi_o);
    end
    if (!bp) begin
      checks++;
      if (cyc != int'(len) + 1) begin
        errors++;
        $display("FAIL write done cycle: got %0d want %0d", cyc, int'(len) + 1);
      end
    end
    bus.wr_v_i = 1'b0;
    step();
    checks++;
    if (bus.done_o !== 1'b0 || bus.cmd_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL write idle: done %b ready %b want 0 1", bus.done_o, bus.cmd_ready_o);
    end
  endtask

  task automatic read_start(input logic [15:0] base, input logic [15:0] stride,
                            input logic [15:0] len);
    rd_base = base; rd_stride = stride; rd_len = len;
    rd_iss = 0; rd_ret = 0; rd_n = 0; rd_done = 0;
    bus.rd_yumi_i = 1'b0;
    send_cmd(1'b0, base, stride, len);
  endtask

  task automatic read_cycle(input bit pop_en);
    logic [15:0] ea;
    logic [31:0] ed;
    checks++;
    if (bus.wo_v_o !== 1'b0) begin
      errors++;
      $display("FAIL wo_v during read: got %b want 0", bus.wo_v_o);
    end
    if (bus.ro_v_o) begin
      ea = rd_base + 16'(rd_iss) * rd_stride;
      checks++;
      if (bus.ro_addr_o !== ea) begin
        errors++;
        $display("FAIL ro_addr issue %0d: got %h want %h", rd_iss, bus.ro_addr_o, ea);
      end
      rd_iss++;
    end
    if (bus.done_o) begin
      rd_done++;
      checks++;
      if (rd_ret != int'(rd_len)) begin
        errors++;
        $display("FAIL read done early: returns %0d want %0d", rd_ret, rd_len);
      end
    end
    if (bus.ro_v_i) rd_ret++;
    if (pop_en && bus.rd_v_o) begin
      ea = rd_base + 16'(rd_n) * rd_stride;
      ed = {16'hDA7A, ea};
      checks++;
      if (bus.rd_data_o !== ed) begin
        errors++;
        $display("FAIL rd_data elem %0d: got %h want %h", rd_n, bus.rd_data_o, ed);
      end
      rd_n++;
      bus.rd_yumi_i = 1'b1;
    end else begin
      bus.rd_yumi_i = 1'b0;
    end
    step();
  endtask

  task automatic read_drain();
    int budget = 0;
    while (!(rd_done > 0 && rd_n == int'(rd_len)) && budget < 200) begin
      read_cycle(1'b1);
      budget++;
    end
    bus.rd_yumi_i = 1'b0;
    checks++;
    if (rd_iss != int'(rd_len) || rd_ret != int'(rd_len) || rd_n != int'(rd_len) || rd_done != 1) begin
      errors++;
      $display("FAIL read totals: issues %0d returns %0d popped %0d dones %0d want %0d %0d %0d 1",
               rd_iss, rd_ret, rd_n, rd_done, rd_len, rd_len, rd_len);
    end
    checks++;
    if (bus.error_o !== 1'b0 || bus.rd_v_o !== 1'b0 || bus.cmd_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL read end: error %b rd_v %b ready %b want 0 0 1",
               bus.error_o, bus.rd_v_o, bus.cmd_ready_o);
    end
  endtask

  task automatic test_read_credit();
    read_start(16'h0100, 16'h0001, 16'd8);
    repeat (12) read_cycle(1'b0);
    checks++;
    if (rd_iss != 4 || rd_ret != 4 || bus.ro_v_o !== 1'b0) begin
      errors++;
      $display("FAIL credit stall: issues %0d returns %0d ro_v %b want 4 4 0",
               rd_iss, rd_ret, bus.ro_v_o);
    end
    checks++;
    if (bus.rd_v_o !== 1'b1 || bus.rd_data_o !== 32'hDA7A_0100 || bus.done_o !== 1'b0) begin
      errors++;
      $display("FAIL credit head: rd_v %b data %h done %b want 1 DA7A0100 0",
               bus.rd_v_o, bus.rd_data_o, bus.done_o);
    end
    read_cycle(1'b1);
    repeat (10) read_cycle(1'b0);
    checks++;
    if (rd_iss != 5 || rd_ret != 5 || bus.ro_v_o !== 1'b0) begin
      errors++;
      $display("FAIL credit after pop: issues %0d returns %0d ro_v %b want 5 5 0",
               rd_iss, rd_ret, bus.ro_v_o);
    end
    read_drain();
  endtask

  task automatic test_len0();
    read_start(16'h0500, 16'h0001, 16'd0);
    checks++;
    if (bus.done_o !== 1'b1 || bus.ro_v_o !== 1'b0 || bus.cmd_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL len0 read: done %b ro_v %b ready %b want 1 0 0",
               bus.done_o, bus.ro_v_o, bus.cmd_ready_o);
    end
    step();
    bus.wr_v_i = 1'b1;
    send_cmd(1'b1, 16'h0600, 16'h0001, 16'd0);
    checks++;
    if (bus.done_o !== 1'b1 || bus.wo_v_o !== 1'b0 || bus.wr_yumi_o !== 1'b0) begin
      errors++;
      $display("FAIL len0 write: done %b wo_v %b yumi %b want 1 0 0",
               bus.done_o, bus.wo_v_o, bus.wr_yumi_o);
    end
    bus.wr_v_i = 1'b0;
    step();
    checks++;
    if (bus.done_o !== 1'b0 || bus.cmd_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL len0 idle: done %b ready %b want 0 1", bus.done_o, bus.cmd_ready_o);
    end
  endtask

  task automatic test_stray();
    model_en = 1'b0;
    stray_d  = 32'hBAD0_BAD0;
    stray_v  = 1'b1;
    step();
    stray_v = 1'b0;
    step();
    checks++;
    if (bus.error_o !== 1'b1 || bus.rd_v_o !== 1'b0) begin
      errors++;
      $display("FAIL stray return: error %b rd_v %b want 1 0", bus.error_o, bus.rd_v_o);
    end
    step();
    checks++;
    if (bus.error_o !== 1'b1) begin
      errors++;
      $display("FAIL error sticky: got %b want 1", bus.error_o);
    end
    model_en = 1'b1;
  endtask

  task automatic test_reset_mid_read();
    read_start(16'h0300, 16'h0002, 16'd8);
    read_cycle(1'b0);
    read_cycle(1'b0);
    checks++;
    if (rd_iss != 2 || rd_ret != 0) begin
      errors++;
      $display("FAIL pre-reset outstanding: issues %0d returns %0d want 2 0", rd_iss, rd_ret);
    end
    rst_n = 1'b0;
    #1;
    test_reset();
    step();
    checks++;
    if (bus.done_o !== 1'b0 || bus.cmd_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL in reset: done %b ready %b want 0 1", bus.done_o, bus.cmd_ready_o);
    end
    rst_n = 1'b1;
    step();
    read_start(16'h0400, 16'h0003, 16'd2);
    read_drain();
  endtask

  initial begin
    rst_n = 1'b0;
    bus.cmd_op_i = 1'b0; bus.cmd_base_i = '0; bus.cmd_stride_i = '0; bus.cmd_len_i = '0;
    bus.cmd_v_i = 1'b0; bus.wr_data_i = '0; bus.wr_v_i = 1'b0; bus.rd_yumi_i = 1'b0;
    bus.wo_ready_i = 1'b0;
    repeat (3) step();
    test_reset();
    rst_n = 1'b1;
    step();
    test_reset();
    run_write(16'h0010, 16'h0004, 16'd3, 1'b0);
    run_write(16'h0200, 16'h0008, 16'd3, 1'b1);
    run_write(16'hFFFC, 16'h0004, 16'd2, 1'b0);
    read_start(16'hFFFC, 16'h0004, 16'd2);
    read_drain();
    test_read_credit();
    test_len0();
    test_stray();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
